// File: rtl/instruction_sequencer_pkg.sv
// ============================================================================
// Module : instruction_sequencer_pkg
// Brief  : Shared opcode, lane and state definitions for the SIMD sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package instruction_sequencer_pkg;

    localparam int          LANES      = 4;
    localparam int          LANE_W     = 2;
    localparam logic [3:0]  OPC_BRANCH = 4'hF;
    localparam logic [3:0]  OPC_HALT   = 4'hE;
    localparam int          SERIAL_BIT = 27;
    localparam int          OPC_MSB    = 31;
    localparam int          OPC_LSB    = 28;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LANE = 2'd1,
        ST_HALT = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic is_branch;
        logic is_halt;
        logic is_serial;
    } decode_t;

endpackage

`default_nettype wire

// File: rtl/instruction_sequencer_if.sv
// ============================================================================
// Module : instruction_sequencer_if
// Brief  : Fetch/PC-control/issue bundle between sequencer, PC and execute.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface instruction_sequencer_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 32
);
    logic [INSTR_W-1:0] instr_in;
    logic               exec_ready;
    logic               vector;
    logic [1:0]         offset;
    logic               jump_enable;
    logic [ADDR_W-1:0]  jump_address;
    logic               issue_valid;
    logic [INSTR_W-1:0] issue_instr;
    logic [1:0]         issue_lane;
    logic               issue_all_lanes;
    logic               halted;

    modport master (
        input  instr_in, exec_ready,
        output vector, offset, jump_enable, jump_address,
        output issue_valid, issue_instr, issue_lane, issue_all_lanes, halted
    );

    modport slave (
        output instr_in, exec_ready,
        input  vector, offset, jump_enable, jump_address,
        input  issue_valid, issue_instr, issue_lane, issue_all_lanes, halted
    );
endinterface

`default_nettype wire

// File: rtl/instruction_sequencer.sv
// ============================================================================
// Module : instruction_sequencer
// Brief  : Decodes fetched instructions, steers program_counter, issues
//          vector or lane-serial work to execute. Rev 1.0 initial release.
// ============================================================================
`default_nettype none

module instruction_sequencer
    import instruction_sequencer_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 32
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    instruction_sequencer_if.master    bus
);

    localparam logic [LANE_W-1:0] c_lane_last = LANE_W'(LANES - 1);

    function automatic decode_t decode(input logic [INSTR_W-1:0] instr);
        decode_t d;
        d.is_branch = (instr[OPC_MSB:OPC_LSB] == OPC_BRANCH);
        d.is_halt   = (instr[OPC_MSB:OPC_LSB] == OPC_HALT);
        d.is_serial = instr[SERIAL_BIT] && !d.is_branch && !d.is_halt;
        return d;
    endfunction

    seq_state_t         r_state,  w_state_nxt;
    logic [LANE_W-1:0]  r_lane_cnt, w_lane_nxt;
    logic               r_issue_valid, w_issue_valid_nxt;
    logic [INSTR_W-1:0] r_issue_instr, w_issue_instr_nxt;
    logic [1:0]         r_issue_lane,  w_issue_lane_nxt;
    logic               r_issue_all,   w_issue_all_nxt;
    logic               r_halted,      w_halted_nxt;
    decode_t            w_dec;

    assign w_dec = decode(bus.instr_in);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_RUN;
            r_lane_cnt    <= '0;
            r_issue_valid <= 1'b0;
            r_issue_instr <= '0;
            r_issue_lane  <= '0;
            r_issue_all   <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_lane_cnt    <= w_lane_nxt;
            r_issue_valid <= w_issue_valid_nxt;
            r_issue_instr <= w_issue_instr_nxt;
            r_issue_lane  <= w_issue_lane_nxt;
            r_issue_all   <= w_issue_all_nxt;
            r_halted      <= w_halted_nxt;
        end
    end

    // Without exec_ready everything holds, so a stalled lane is neither lost nor replayed.
    always_comb begin
        w_state_nxt       = r_state;
        w_lane_nxt        = r_lane_cnt;
        w_issue_valid_nxt = r_issue_valid;
        w_issue_instr_nxt = r_issue_instr;
        w_issue_lane_nxt  = r_issue_lane;
        w_issue_all_nxt   = r_issue_all;
        w_halted_nxt      = r_halted;
        if (bus.exec_ready) begin
            case (r_state)
                ST_RUN: begin
                    if (w_dec.is_branch) begin
                        w_issue_valid_nxt = 1'b0;
                    end else if (w_dec.is_halt) begin
                        w_issue_valid_nxt = 1'b0;
                        w_halted_nxt      = 1'b1;
                        w_state_nxt       = ST_HALT;
                    end else begin
                        w_issue_valid_nxt = 1'b1;
                        w_issue_instr_nxt = bus.instr_in;
                        w_issue_lane_nxt  = 2'd0;
                        w_issue_all_nxt   = !w_dec.is_serial;
                        if (w_dec.is_serial) begin
                            w_lane_nxt  = LANE_W'(1);
                            w_state_nxt = ST_LANE;
                        end
                    end
                end
                ST_LANE: begin
                    w_issue_valid_nxt = 1'b1;
                    w_issue_instr_nxt = bus.instr_in;
                    w_issue_lane_nxt  = r_lane_cnt;
                    w_issue_all_nxt   = 1'b0;
                    if (r_lane_cnt == c_lane_last) begin
                        w_lane_nxt  = '0;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_lane_nxt  = r_lane_cnt + LANE_W'(1);
                    end
                end
                ST_HALT: begin
                    w_issue_valid_nxt = 1'b0;
                    w_halted_nxt      = 1'b1;
                end
                default: begin
                    w_state_nxt = ST_RUN;
                    w_lane_nxt  = '0;
                end
            endcase
        end
    end

    // PC control is gated by reset so program_counter never sees a jump while held.
    always_comb begin
        bus.vector       = 1'b0;
        bus.offset       = 2'd0;
        bus.jump_enable  = 1'b0;
        bus.jump_address = '0;
        if (reset) begin
            bus.offset = r_lane_cnt;
            if (bus.exec_ready) begin
                case (r_state)
                    ST_RUN: begin
                        if (w_dec.is_branch) begin
                            bus.jump_enable  = 1'b1;
                            bus.jump_address = bus.instr_in[ADDR_W-1:0];
                        end else if (!w_dec.is_halt && !w_dec.is_serial) begin
                            bus.vector = 1'b1;
                        end
                    end
                    ST_LANE: bus.vector = (r_lane_cnt == c_lane_last);
                    default: bus.vector = 1'b0;
                endcase
            end
        end
    end

    assign bus.issue_valid     = r_issue_valid;
    assign bus.issue_instr     = r_issue_instr;
    assign bus.issue_lane      = r_issue_lane;
    assign bus.issue_all_lanes = r_issue_all;
    assign bus.halted          = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_instruction_sequencer.sv
// ============================================================================
// Module : tb_instruction_sequencer
// Brief  : Sequencer with a program_counter model and a 256x32 ROM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instruction_sequencer;

    localparam logic [31:0] A0 = 32'h1000_00A0;
    localparam logic [31:0] A1 = 32'h1000_00A1;
    localparam logic [31:0] A2 = 32'h1000_00A2;
    localparam logic [31:0] B3 = 32'h0800_00B3;

    logic        clk;
    logic        reset;
    logic        rdy;
    logic [7:0]  pc;
    logic [31:0] rom [256];
    int          checks;
    int          failures;

    instruction_sequencer_if #(.ADDR_W(8), .INSTR_W(32)) bus ();

    instruction_sequencer #(.ADDR_W(8), .INSTR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.instr_in   = rom[pc];
    assign bus.exec_ready = rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)               pc <= 8'd0;
        else if (bus.jump_enable) pc <= bus.jump_address;
        else if (bus.vector)      pc <= pc + 8'd1;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst_n;
        logic        rdy;
        logic [7:0]  pc;
        logic        vec;
        logic [1:0]  off;
        logic        je;
        logic [7:0]  ja;
        logic        iv;
        logic [31:0] ii;
        logic [1:0]  il;
        logic        ia;
        logic        h;
    } row_t;

    row_t tbl[$];

    function automatic row_t mk(input logic rst_n, input logic r, input logic [7:0] p,
                                input logic v, input logic [1:0] o, input logic je,
                                input logic [7:0] ja, input logic iv, input logic [31:0] ii,
                                input logic [1:0] il, input logic ia, input logic h);
        row_t x;
        x.rst_n = rst_n; x.rdy = r;  x.pc = p;   x.vec = v;  x.off = o;  x.je = je;
        x.ja    = ja;    x.iv  = iv; x.ii = ii;  x.il  = il; x.ia  = ia; x.h  = h;
        return x;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic push_prologue();
        tbl.push_back(mk(0,1,  0,0,0,0,8'h00, 0,32'h0,0,0,0));
        tbl.push_back(mk(1,1,  0,1,0,0,8'h00, 0,32'h0,0,0,0));
        tbl.push_back(mk(1,1,  1,1,0,0,8'h00, 1,A0,0,1,0));
        tbl.push_back(mk(1,1,  2,1,0,0,8'h00, 1,A1,0,1,0));
        tbl.push_back(mk(1,1,  3,0,0,0,8'h00, 1,A2,0,1,0));
        tbl.push_back(mk(1,1,  3,0,1,0,8'h00, 1,B3,0,0,0));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        rdy      = 1'b1;
        for (int i = 0; i < 256; i++) rom[i] = 32'h0;
        rom[0]  = A0;
        rom[1]  = A1;
        rom[2]  = A2;
        rom[3]  = B3;
        rom[4]  = 32'hF000_0014;
        rom[20] = 32'hE000_0000;

        // Pass 1: vector run, lane-serial, branch, halt
        push_prologue();
        tbl.push_back(mk(1,1,  3,0,2,0,8'h00, 1,B3,1,0,0));
        tbl.push_back(mk(1,1,  3,1,3,0,8'h00, 1,B3,2,0,0));
        tbl.push_back(mk(1,1,  4,0,0,1,8'h14, 1,B3,3,0,0));
        tbl.push_back(mk(1,1, 20,0,0,0,8'h00, 0,32'h0,0,0,0));
        tbl.push_back(mk(1,1, 20,0,0,0,8'h00, 0,32'h0,0,0,1));
        tbl.push_back(mk(1,1, 20,0,0,0,8'h00, 0,32'h0,0,0,1));
        // Pass 2: backpressure at lane 2 and on the branch
        push_prologue();
        tbl.push_back(mk(1,0,  3,0,2,0,8'h00, 1,B3,1,0,0));
        tbl.push_back(mk(1,0,  3,0,2,0,8'h00, 1,B3,1,0,0));
        tbl.push_back(mk(1,0,  3,0,2,0,8'h00, 1,B3,1,0,0));
        tbl.push_back(mk(1,1,  3,0,2,0,8'h00, 1,B3,1,0,0));
        tbl.push_back(mk(1,1,  3,1,3,0,8'h00, 1,B3,2,0,0));
        tbl.push_back(mk(1,0,  4,0,0,0,8'h00, 1,B3,3,0,0));
        tbl.push_back(mk(1,1,  4,0,0,1,8'h14, 1,B3,3,0,0));
        tbl.push_back(mk(1,1, 20,0,0,0,8'h00, 0,32'h0,0,0,0));
        tbl.push_back(mk(1,1, 20,0,0,0,8'h00, 0,32'h0,0,0,1));
        tbl.push_back(mk(1,0, 20,0,0,0,8'h00, 0,32'h0,0,0,1));
        // Pass 3: walk up to lane 1 for the asynchronous reset sequence
        push_prologue();

        foreach (tbl[i]) begin
            @(negedge clk);
            reset = tbl[i].rst_n;
            rdy   = tbl[i].rdy;
            #1;
            chk("pc",          i, 32'(pc),               32'(tbl[i].pc));
            chk("vector",      i, 32'(bus.vector),       32'(tbl[i].vec));
            chk("offset",      i, 32'(bus.offset),       32'(tbl[i].off));
            chk("jump_enable", i, 32'(bus.jump_enable),  32'(tbl[i].je));
            if (tbl[i].je || !tbl[i].rst_n)
                chk("jump_address", i, 32'(bus.jump_address), 32'(tbl[i].ja));
            chk("issue_valid", i, 32'(bus.issue_valid),  32'(tbl[i].iv));
            if (tbl[i].iv || !tbl[i].rst_n) begin
                chk("issue_instr",     i, bus.issue_instr,          tbl[i].ii);
                chk("issue_lane",      i, 32'(bus.issue_lane),      32'(tbl[i].il));
                chk("issue_all_lanes", i, 32'(bus.issue_all_lanes), 32'(tbl[i].ia));
            end
            chk("halted",      i, 32'(bus.halted),       32'(tbl[i].h));
        end

        // Asynchronous reset mid-LANE, asserted and released between clock edges
        #1;
        reset = 1'b0;
        #1;
        chk("async_issue_valid", 100, 32'(bus.issue_valid), 32'h0);
        chk("async_offset",      100, 32'(bus.offset),      32'h0);
        chk("async_pc",          100, 32'(pc),              32'h0);
        chk("async_issue_lane",  100, 32'(bus.issue_lane),  32'h0);
        reset = 1'b1;
        #1;
        chk("release_offset",    101, 32'(bus.offset),      32'h0);
        chk("release_vector",    101, 32'(bus.vector),      32'h1);
        chk("release_halted",    101, 32'(bus.halted),      32'h0);
        @(negedge clk);
        #1;
        chk("restart_pc",        102, 32'(pc),                  32'h1);
        chk("restart_issue_all", 102, 32'(bus.issue_all_lanes), 32'h1);
        chk("restart_instr",     102, bus.issue_instr,          A0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
